// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared 25-bit adder arbiter.
package adder_arb_pkg;

  localparam int unsigned ADD_W = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Saturation bounds: largest positive and most negative 25-bit signed values
  localparam logic [ADD_W-1:0] SAT_MAX = 25'h0FFFFFF;
  localparam logic [ADD_W-1:0] SAT_MIN = 25'h1000000;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bus between ALU issue ports and the shared adder arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import adder_arb_pkg::*;

  localparam int unsigned WIDTH = ADD_W;
  localparam int unsigned IDW   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_ovf;

  // Requesters and result consumer
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/adder_share_arbiter_rca.sv
// Team 25-bit ripple-carry adder (width parameterised, default 25).
module rca_adder #(
  parameter int unsigned W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  // Bit-serial carry chain
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[W];
  end

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW:0]   pos;
  logic [IDW-1:0] cand;

  // Scan candidates in priority order starting at ptr
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NUM_REQ)) begin
        pos = pos - (IDW+1)'(NUM_REQ);
      end
      cand = pos[IDW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 25-bit ripple-carry adder among NUM_REQ requesters with
// round-robin arbitration and a registered sum/carry/overflow response.
// Optional feature macro: ADDER_ARB_SAT_EN (saturate rsp_sum on signed overflow).
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_share_arbiter_if.slave  bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned MSB = ADD_W - 1;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADD_W-1:0] op_a_q, op_a_d;
  logic [ADD_W-1:0] op_b_q, op_b_d;
  logic             op_sub_q, op_sub_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [ADD_W-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic [ADD_W-1:0] a_arr [NUM_REQ];
  logic [ADD_W-1:0] b_arr [NUM_REQ];

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic               gnt_en_c;

  logic [ADD_W-1:0] b_eff;
  logic [ADD_W-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic [ADD_W-1:0] res_sum;

  // Unpack the flat operand buses per requester
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = bus.req_a[i*ADD_W +: ADD_W];
      b_arr[i] = bus.req_b[i*ADD_W +: ADD_W];
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Grants are offered only when the datapath can take a new op this cycle
  assign gnt_en_c      = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign bus.req_ready = gnt_en_c ? arb_gnt : '0;

  // Subtraction reuses the single adder via B inversion and carry-in
  assign b_eff = op_sub_q ? ~op_b_q : op_b_q;

  rca_adder #(.W(ADD_W)) u_add (
    .a    (op_a_q),
    .b    (b_eff),
    .cin  (op_sub_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (op_a_q[MSB] == b_eff[MSB]) && (add_sum[MSB] != op_a_q[MSB]);

  // Result selection: raw wrapped sum or saturated sum on overflow
  always_comb begin
`ifdef ADDER_ARB_SAT_EN
    res_sum = add_ovf ? (op_a_q[MSB] ? SAT_MIN : SAT_MAX) : add_sum;
`else
    res_sum = add_sum;
`endif
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;

    if (gnt_en_c && arb_any) begin
      op_a_d   = a_arr[arb_idx];
      op_b_d   = b_arr[arb_idx];
      op_sub_d = bus.req_sub[arb_idx];
      op_id_d  = arb_idx;
      rr_ptr_d = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
    end

    case (state_q)
      IDLE: begin
        if (arb_any) state_d = ADD;
      end
      ADD: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_id_q;
        rsp_sum_d   = res_sum;
        rsp_cout_d  = add_cout;
        rsp_ovf_d   = add_ovf;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = arb_any ? ADD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sub_q    <= op_sub_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NUM_REQ=4).
module tb_adder_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 25;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  adder_share_arbiter_if #(.NUM_REQ(N)) bus ();

  adder_share_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_sub[i]      = sub;
  endtask

  // Present one op from requester i alone, then advance to RESP
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    set_req(i, a, b, sub);
    bus.req_valid = 4'(1 << i);
    #1;
    check("issue_ready", 32'(bus.req_ready), 32'(1 << i));
    step();
    bus.req_valid = '0;
    #1;
    check("add_ready_low", 32'(bus.req_ready), 32'd0);
    check("add_valid_low", 32'(bus.rsp_valid), 32'd0);
    step();
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("drain_valid_low", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input int id, input logic [W-1:0] sum,
                           input logic cout, input logic ovf);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    check({tag, "_sum"},   32'(bus.rsp_sum),   32'(sum));
    check({tag, "_cout"},  32'(bus.rsp_cout),  32'(cout));
    check({tag, "_ovf"},   32'(bus.rsp_ovf),   32'(ovf));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    step();
    step();
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_id",    32'(bus.rsp_id),    32'd0);
    check("rst_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst_cout",  32'(bus.rsp_cout),  32'd0);
    check("rst_ovf",   32'(bus.rsp_ovf),   32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_no_req_ready", 32'(bus.req_ready), 32'd0);
    check("idle_no_req_valid", 32'(bus.rsp_valid), 32'd0);

    // Single add: 5 + 7 from requester 0 (rr_ptr -> 1)
    issue(0, 25'd5, 25'd7, 1'b0);
    check_rsp("add", 0, 25'd12, 1'b0, 1'b0);
    drain();

    // Subtract: 3 - 10 from requester 2 (rr_ptr -> 3)
    issue(2, 25'd3, 25'd10, 1'b1);
    check_rsp("sub", 2, 25'h1FFFFF9, 1'b0, 1'b0);
    drain();

    // Positive overflow from requester 3 (rr_ptr wraps -> 0)
`ifdef ADDER_ARB_SAT_EN
    issue(3, 25'h0FFFFFF, 25'd1, 1'b0);
    check_rsp("ovf", 3, 25'h0FFFFFF, 1'b0, 1'b1);
`else
    issue(3, 25'h0FFFFFF, 25'd1, 1'b0);
    check_rsp("ovf", 3, 25'h1000000, 1'b0, 1'b1);
`endif
    drain();

    // Carry-out without overflow: -1 + 1 from requester 1 (rr_ptr -> 2)
    issue(1, 25'h1FFFFFF, 25'd1, 1'b0);
    check_rsp("cout", 1, 25'd0, 1'b1, 1'b0);
    drain();

    // Reset while in ADD: op is dropped and all state returns to reset
    set_req(3, 25'd9, 25'd9, 1'b0);
    bus.req_valid = 4'b1000;
    #1;
    check("rstadd_ready", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstadd_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstadd_sum",   32'(bus.rsp_sum),   32'd0);
    check("rstadd_cout",  32'(bus.rsp_cout),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rstadd_no_rsp1", 32'(bus.rsp_valid), 32'd0);
    step();
    check("rstadd_no_rsp2", 32'(bus.rsp_valid), 32'd0);

    // Fairness: all four valid, consumer always ready -> 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, 25'(i + 1), 25'd100, 1'b0);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    check("fair_first_ready", 32'(bus.req_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check("fair_add_valid", 32'(bus.rsp_valid), 32'd0);
      check("fair_add_ready", 32'(bus.req_ready), 32'd0);
      step();
      check("fair_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("fair_rsp_id",    32'(bus.rsp_id),    32'(k % 4));
      check("fair_rsp_sum",   32'(bus.rsp_sum),   32'((k % 4) + 101));
      check("fair_next_gnt",  32'(bus.req_ready), 32'(1 << ((k + 1) % 4)));
    end
    bus.req_valid = '0;
    step();
    bus.rsp_ready = 1'b0;
    check("fair_end_valid", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: hold response 5 cycles, then same-cycle grant to req1
    set_req(0, 25'd20, 25'd22, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    check("bp_first_ready", 32'(bus.req_ready), 32'b0001);
    step();
    set_req(1, 25'd50, 25'd7, 1'b1);
    bus.req_valid = 4'b0010;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_sum",   32'(bus.rsp_sum),   32'd42);
      check("bp_hold_id",    32'(bus.rsp_id),    32'd0);
      check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(bus.req_ready), 32'b0010);
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    check("bp_add_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    check_rsp("bp_req1", 1, 25'd43, 1'b1, 1'b0);
    drain();
    step();
    check("final_idle_ready", 32'(bus.req_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
